// File: rtl/regfile_pkg.sv
// Shared defaults and address qualification for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DefN        = 8;
  localparam int unsigned DefAddrW    = 5;
  localparam int unsigned DefRegCount = 32;

  // An address is live when it names a real register that is not the hardwired zero.
  function automatic logic addr_live(input int unsigned addr, input int unsigned reg_count,
                                     input bit zero_reg);
    return (addr < reg_count) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding writer and flags WAW issues.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned REGCOUNT = DefRegCount
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              we_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] rw_i,
  input  logic              issue_i,
  input  logic              ri_live_i,
  input  logic [ADDR_W-1:0] ri_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic              byp1_i,
  input  logic              byp2_i,
  output logic              rd1_valid_o,
  output logic              rd2_valid_o,
  output logic              issue_stall_o,
  output logic              busy_any_o
);

  logic [REGCOUNT-1:0] busy_q, busy_d;
  logic                rs1_busy, rs2_busy, ri_busy;
  logic                issue_ok;

  // Dead addresses never match a slot, so they read as not busy.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    ri_busy  = 1'b0;
    for (int unsigned i = 0; i < REGCOUNT; i++) begin
      if (rs1_i == ADDR_W'(i)) rs1_busy = busy_q[i];
      if (rs2_i == ADDR_W'(i)) rs2_busy = busy_q[i];
      if (ri_i == ADDR_W'(i))  ri_busy  = busy_q[i];
    end
  end

  assign rd1_valid_o   = byp1_i | ~rs1_busy;
  assign rd2_valid_o   = byp2_i | ~rs2_busy;
  assign issue_stall_o = issue_i & ri_busy & ~(we_i & (rw_i == ri_i));
  assign issue_ok      = issue_i & ri_live_i & ~issue_stall_o;
  assign busy_any_o    = |busy_q;

  // Issue is applied after writeback so a same-edge reservation wins the busy bit.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < REGCOUNT; i++) begin
      if (wr_en_i && (rw_i == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (issue_ok && (ri_i == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write-to-read bypass and a busy-bit scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned N        = DefN,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned REGCOUNT = DefRegCount,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [N-1:0]      Data,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic [N-1:0]      Rd1,
  output logic [N-1:0]      Rd2,
  output logic              Rd1Valid,
  output logic              Rd2Valid,
  input  logic              Issue,
  input  logic [ADDR_W-1:0] Ri,
  output logic              IssueStall,
  output logic              BusyAny
);

  logic [N-1:0] regs_q [REGCOUNT];
  logic [N-1:0] regs_d [REGCOUNT];
  logic [N-1:0] arr1, arr2;
  logic         wr_en, ri_live, byp1, byp2;

  assign wr_en   = WE & addr_live(32'(Rw), REGCOUNT, ZERO_REG);
  assign ri_live = addr_live(32'(Ri), REGCOUNT, ZERO_REG);

  // Forwarding is suppressed under reset so the read ports show the cleared state.
  assign byp1 = BYPASS & wr_en & ~Reset & (Rw == Rs1);
  assign byp2 = BYPASS & wr_en & ~Reset & (Rw == Rs2);

  // Slot 0 is never written when hardwired, so it always reads back zero.
  always_comb begin
    arr1 = '0;
    arr2 = '0;
    for (int unsigned i = 0; i < REGCOUNT; i++) begin
      if (Rs1 == ADDR_W'(i)) arr1 = regs_q[i];
      if (Rs2 == ADDR_W'(i)) arr2 = regs_q[i];
    end
  end

  assign Rd1 = byp1 ? Data : arr1;
  assign Rd2 = byp2 ? Data : arr2;

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < REGCOUNT; i++) begin
      if (wr_en && (Rw == ADDR_W'(i))) regs_d[i] = Data;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .REGCOUNT (REGCOUNT)
  ) u_scoreboard (
    .Clock         (Clock),
    .Reset         (Reset),
    .we_i          (WE),
    .wr_en_i       (wr_en),
    .rw_i          (Rw),
    .issue_i       (Issue),
    .ri_live_i     (ri_live),
    .ri_i          (Ri),
    .rs1_i         (Rs1),
    .rs2_i         (Rs2),
    .byp1_i        (byp1),
    .byp2_i        (byp2),
    .rd1_valid_o   (Rd1Valid),
    .rd2_valid_o   (Rd2Valid),
    .issue_stall_o (IssueStall),
    .busy_any_o    (BusyAny)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: array-based reference model plus literal spot checks.
module tb_regfile_sb;

  logic       Clock, Reset, WE, Issue;
  logic [4:0] Rw, Rs1, Rs2, Ri;
  logic [7:0] Data, Rd1, Rd2;
  logic       Rd1Valid, Rd2Valid, IssueStall, BusyAny;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [32] = '{default: '0};
  logic       m_busy [32] = '{default: 1'b0};

  regfile_sb dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WE         (WE),
    .Rw         (Rw),
    .Data       (Data),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .Rd1        (Rd1),
    .Rd2        (Rd2),
    .Rd1Valid   (Rd1Valid),
    .Rd2Valid   (Rd2Valid),
    .Issue      (Issue),
    .Ri         (Ri),
    .IssueStall (IssueStall),
    .BusyAny    (BusyAny)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 32 registers, register 0 hardwired to zero.
  function automatic bit live(input logic [4:0] a);
    return a != 5'd0;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [4:0] a);
    if (!live(a) || Reset) return 8'h00;
    if (WE && Rw == a) return Data;
    return m_regs[a];
  endfunction

  function automatic logic exp_valid(input logic [4:0] a);
    if (!live(a) || Reset) return 1'b1;
    if (WE && Rw == a) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic logic exp_stall();
    return Issue && live(Ri) && m_busy[Ri] && !(WE && Rw == Ri);
  endfunction

  function automatic logic exp_busy_any();
    logic any = 1'b0;
    for (int i = 0; i < 32; i++) any = any | m_busy[i];
    return any;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 8'h00;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (WE && live(Rw)) begin
        m_regs[Rw] <= Data;
        m_busy[Rw] <= 1'b0;
      end
      if (Issue && live(Ri) && !exp_stall()) m_busy[Ri] <= 1'b1;
    end
  end

  always @(negedge Clock) begin
    chk("cmp_rd1",    Rd1,        exp_rd(Rs1));
    chk("cmp_rd2",    Rd2,        exp_rd(Rs2));
    chk("cmp_valid1", Rd1Valid,   exp_valid(Rs1));
    chk("cmp_valid2", Rd2Valid,   exp_valid(Rs2));
    chk("cmp_stall",  IssueStall, exp_stall());
    chk("cmp_busy",   BusyAny,    exp_busy_any());
  end

  task automatic next_cycle();
    @(posedge Clock);
    #1;
    WE    = 1'b0;
    Issue = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    WE = 1'b0; Issue = 1'b0;
    Rw = 5'd0; Rs1 = 5'd0; Rs2 = 5'd0; Ri = 5'd0; Data = 8'h00;
    next_cycle();
    next_cycle();
    Reset = 1'b0;

    // Every register reads zero and valid after reset.
    for (int a = 0; a < 32; a++) begin
      next_cycle();
      Rs1 = 5'(a);
      Rs2 = 5'(31 - a);
      #2;
      chk("rst_rd1", Rd1, 8'h00);
      chk("rst_valid1", Rd1Valid, 1'b1);
      chk("rst_rd2", Rd2, 8'h00);
    end

    // Same-cycle bypass, then stored value.
    next_cycle();
    WE = 1'b1; Rw = 5'd5; Data = 8'hA5; Rs1 = 5'd5;
    #2;
    chk("byp_rd1", Rd1, 8'hA5);
    chk("byp_valid1", Rd1Valid, 1'b1);
    next_cycle();
    #2;
    chk("stored_rd1", Rd1, 8'hA5);

    // Reservation, WAW stall, writeback clears.
    next_cycle();
    Issue = 1'b1; Ri = 5'd3; Rs2 = 5'd3;
    #2;
    chk("issue3_stall", IssueStall, 1'b0);
    next_cycle();
    #2;
    chk("busy3_valid2", Rd2Valid, 1'b0);
    chk("busy3_any", BusyAny, 1'b1);
    next_cycle();
    Issue = 1'b1; Ri = 5'd3;
    #2;
    chk("waw3_stall", IssueStall, 1'b1);
    next_cycle();
    WE = 1'b1; Rw = 5'd3; Data = 8'h11;
    #2;
    chk("wb3_rd2", Rd2, 8'h11);
    chk("wb3_valid2", Rd2Valid, 1'b1);
    next_cycle();
    #2;
    chk("wb3_any", BusyAny, 1'b0);
    chk("wb3_stored", Rd2, 8'h11);

    // Write and re-issue on the same edge: data lands, busy stays set.
    next_cycle();
    Issue = 1'b1; Ri = 5'd7;
    next_cycle();
    Issue = 1'b1; Ri = 5'd7; WE = 1'b1; Rw = 5'd7; Data = 8'h3C;
    #2;
    chk("wi7_stall", IssueStall, 1'b0);
    next_cycle();
    Rs1 = 5'd7;
    #2;
    chk("wi7_rd1", Rd1, 8'h3C);
    chk("wi7_valid1", Rd1Valid, 1'b0);
    chk("wi7_any", BusyAny, 1'b1);
    next_cycle();
    WE = 1'b1; Rw = 5'd7; Data = 8'h42;
    next_cycle();
    #2;
    chk("wb7_any", BusyAny, 1'b0);

    // Hardwired zero register ignores writes and issues.
    next_cycle();
    WE = 1'b1; Rw = 5'd0; Data = 8'hFF; Issue = 1'b1; Ri = 5'd0; Rs1 = 5'd0; Rs2 = 5'd0;
    #2;
    chk("zero_rd1", Rd1, 8'h00);
    chk("zero_valid1", Rd1Valid, 1'b1);
    chk("zero_stall", IssueStall, 1'b0);
    next_cycle();
    #2;
    chk("zero_rd2", Rd2, 8'h00);
    chk("zero_any", BusyAny, 1'b0);

    // Asynchronous reset with register 3 reserved and holding 8'h11.
    next_cycle();
    Issue = 1'b1; Ri = 5'd3;
    next_cycle();
    Rs1 = 5'd3; Rs2 = 5'd4;
    #2;
    chk("pre_rst_rd1", Rd1, 8'h11);
    chk("pre_rst_any", BusyAny, 1'b1);
    #3;
    Reset = 1'b1;
    WE = 1'b1; Rw = 5'd3; Data = 8'h77; Issue = 1'b1; Ri = 5'd4;
    #1;
    chk("arst_rd1", Rd1, 8'h00);
    chk("arst_valid1", Rd1Valid, 1'b1);
    chk("arst_any", BusyAny, 1'b0);
    chk("arst_stall", IssueStall, 1'b0);
    next_cycle();
    next_cycle();
    Reset = 1'b0;
    WE = 1'b1; Rw = 5'd9; Data = 8'h5A; Rs1 = 5'd9; Rs2 = 5'd3;
    #2;
    chk("post_rst_byp", Rd1, 8'h5A);
    chk("post_rst_rd2", Rd2, 8'h00);
    next_cycle();
    Rs2 = 5'd4;
    #2;
    chk("post_rst_rd1", Rd1, 8'h5A);
    chk("post_rst_valid2", Rd2Valid, 1'b1);

    // Fill every register with a distinct pattern; the compare process checks reads.
    for (int a = 1; a < 32; a++) begin
      next_cycle();
      WE = 1'b1; Rw = 5'(a); Data = 8'(a * 37 + 1);
      Rs1 = 5'(a); Rs2 = 5'(a - 1);
    end
    for (int a = 0; a < 32; a++) begin
      next_cycle();
      Rs1 = 5'(a); Rs2 = 5'(31 - a);
    end
    next_cycle();
    Rs1 = 5'd31;
    #2;
    chk("fill_rd31", Rd1, 8'(31 * 37 + 1));
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
